// File: rtl/paint_pkg.sv
// Shared types for the frame paint sequencer.
//   element_t      : one element descriptor, six COOR_WIDTH-bit fields,
//                    {sprite_x, sprite_y, frame_x, frame_y, width, height}
//   sched_state_t  : sequencer states
//   is_empty()     : an entry with zero width or zero height paints nothing
package paint_pkg;

    localparam int COOR_WIDTH    = 11;
    localparam int ELEMENT_COUNT = 32;
    localparam int ELEMENT_WIDTH = 5;

    typedef struct packed {
        logic [COOR_WIDTH-1:0] sprite_x;
        logic [COOR_WIDTH-1:0] sprite_y;
        logic [COOR_WIDTH-1:0] frame_x;
        logic [COOR_WIDTH-1:0] frame_y;
        logic [COOR_WIDTH-1:0] width;
        logic [COOR_WIDTH-1:0] height;
    } element_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BG_START,
        S_BG_RUN,
        S_FETCH,
        S_CHECK,
        S_EL_START,
        S_EL_RUN,
        S_DONE
    } sched_state_t;

    function automatic logic is_empty(input element_t e);
        return (e.width == '0) || (e.height == '0);
    endfunction

endpackage

// File: rtl/paint_scheduler_element_table.sv
// Element descriptor table: simple dual-port RAM, one write port and one
// synchronous read port (1-cycle latency). No reset so it maps onto block RAM.
// A read and a write to the same address in the same cycle return the old
// contents (read-before-write).
//   clk    : clock
//   we     : write strobe, waddr/wdata : write index/data
//   re     : read enable,  raddr       : read index
//   rdata  : registered read data, holds when re is low
module element_table
    import paint_pkg::*;
#(
    parameter int DEPTH = ELEMENT_COUNT,
    parameter int AW    = ELEMENT_WIDTH
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  element_t      wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output element_t      rdata
);

    element_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/paint_scheduler.sv
// Frame-level sequencer for the sprite painting datapath. Each frame_start
// runs paint_background once, then walks the descriptor table in index order
// and fires paint_element for every non-empty entry.
//   clk_33m, rst (async, active-high)
//   frame_start         : begin a new frame (ignored and flagged when busy)
//   desc_we/addr/wdata  : descriptor table write port (any state)
//   bg_finished         : paint_background done
//   el_finished         : paint_element done
//   bg_rst, el_rst      : painter resets, 1 = hold idle
//   el_desc             : descriptor presented to paint_element
//   painting_background : pixel-source select, 1 = background
//   busy                : frame in progress
//   frame_done          : 1-cycle pulse at end of frame
//   overrun             : 1-cycle pulse, frame_start arrived while busy
module paint_scheduler
    import paint_pkg::*;
#(
    parameter int ELEMENT_COUNT = paint_pkg::ELEMENT_COUNT,
    parameter int ELEMENT_WIDTH = paint_pkg::ELEMENT_WIDTH
) (
    input  logic                     clk_33m,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic                     desc_we,
    input  logic [ELEMENT_WIDTH-1:0] desc_addr,
    input  element_t                 desc_wdata,
    input  logic                     bg_finished,
    input  logic                     el_finished,
    output logic                     bg_rst,
    output logic                     el_rst,
    output element_t                 el_desc,
    output logic                     painting_background,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overrun
);

    localparam logic [ELEMENT_WIDTH-1:0] LAST_IDX = ELEMENT_WIDTH'(ELEMENT_COUNT - 1);

    sched_state_t             state;
    logic [ELEMENT_WIDTH-1:0] idx;
    logic                     blank;     // first cycle of a painter run: finished flag not trusted
    element_t                 rd_entry;
    logic                     rd_en;

    assign rd_en = (state == S_FETCH);

    element_table #(
        .DEPTH (ELEMENT_COUNT),
        .AW    (ELEMENT_WIDTH)
    ) u_table (
        .clk   (clk_33m),
        .we    (desc_we),
        .waddr (desc_addr),
        .wdata (desc_wdata),
        .re    (rd_en),
        .raddr (idx),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk_33m or posedge rst) begin
        if (rst) begin
            state               <= S_IDLE;
            idx                 <= '0;
            blank               <= 1'b0;
            bg_rst              <= 1'b1;
            el_rst              <= 1'b1;
            el_desc             <= '0;
            painting_background <= 1'b1;
            busy                <= 1'b0;
            frame_done          <= 1'b0;
            overrun             <= 1'b0;
        end else begin
            overrun    <= frame_start && (state != S_IDLE);
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    bg_rst <= 1'b1;
                    el_rst <= 1'b1;
                    if (frame_start) begin
                        state <= S_BG_START;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_BG_START: begin
                    bg_rst <= 1'b0;
                    blank  <= 1'b1;
                    state  <= S_BG_RUN;
                end
                S_BG_RUN: begin
                    if (blank) begin
                        blank <= 1'b0;
                    end else if (bg_finished) begin
                        bg_rst              <= 1'b1;
                        painting_background <= 1'b0;
                        state               <= S_FETCH;
                    end
                end
                // table read issued here, data valid in CHECK
                S_FETCH: begin
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (is_empty(rd_entry)) begin
                        if (idx == LAST_IDX) begin
                            state      <= S_DONE;
                            frame_done <= 1'b1;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_FETCH;
                        end
                    end else begin
                        el_desc <= rd_entry;
                        state   <= S_EL_START;
                    end
                end
                S_EL_START: begin
                    el_rst <= 1'b0;
                    blank  <= 1'b1;
                    state  <= S_EL_RUN;
                end
                S_EL_RUN: begin
                    if (blank) begin
                        blank <= 1'b0;
                    end else if (el_finished) begin
                        el_rst <= 1'b1;
                        if (idx == LAST_IDX) begin
                            state      <= S_DONE;
                            frame_done <= 1'b1;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    bg_rst              <= 1'b1;
                    el_rst              <= 1'b1;
                    painting_background <= 1'b1;
                    busy                <= 1'b0;
                    state               <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_paint_scheduler.sv
// Directed bench for paint_scheduler: reset values, empty-table frame,
// element sequencing, blanking with el_finished tied high, overrun,
// mid-frame table updates and asynchronous reset mid-frame.
module tb_paint_scheduler;
    import paint_pkg::*;

    logic                     clk_33m = 1'b0;
    logic                     rst;
    logic                     frame_start;
    logic                     desc_we;
    logic [ELEMENT_WIDTH-1:0] desc_addr;
    element_t                 desc_wdata;
    logic                     bg_finished;
    logic                     el_finished;
    logic                     bg_rst;
    logic                     el_rst;
    element_t                 el_desc;
    logic                     painting_background;
    logic                     busy;
    logic                     frame_done;
    logic                     overrun;

    paint_scheduler dut (
        .clk_33m             (clk_33m),
        .rst                 (rst),
        .frame_start         (frame_start),
        .desc_we             (desc_we),
        .desc_addr           (desc_addr),
        .desc_wdata          (desc_wdata),
        .bg_finished         (bg_finished),
        .el_finished         (el_finished),
        .bg_rst              (bg_rst),
        .el_rst              (el_rst),
        .el_desc             (el_desc),
        .painting_background (painting_background),
        .busy                (busy),
        .frame_done          (frame_done),
        .overrun             (overrun)
    );

    always #5 clk_33m = ~clk_33m;

    int n_cmp  = 0;
    int n_fail = 0;

    // per-frame observations filled by run_frame
    element_t painted[$];
    int       low_runs[$];
    int       done_cnt, ovr_cnt, done_c, last_rise_c, bg_low_c;

    element_t e0, e3, e31, a1, a2, a5, b1, b5, zero_e;

    function automatic element_t mk(input int sx, input int sy, input int fx,
                                    input int fy, input int w, input int h);
        element_t e;
        e.sprite_x = COOR_WIDTH'(sx);
        e.sprite_y = COOR_WIDTH'(sy);
        e.frame_x  = COOR_WIDTH'(fx);
        e.frame_y  = COOR_WIDTH'(fy);
        e.width    = COOR_WIDTH'(w);
        e.height   = COOR_WIDTH'(h);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk_33m);
        #1;
    endtask

    task automatic wr(input int addr, input element_t d);
        desc_addr  = ELEMENT_WIDTH'(addr);
        desc_wdata = d;
        desc_we    = 1'b1;
        tick();
        desc_we    = 1'b0;
    endtask

    task automatic clear_table();
        for (int i = 0; i < ELEMENT_COUNT; i++) wr(i, zero_e);
    endtask

    // Drives one frame. fin_delay = 0 ties el_finished high, otherwise
    // el_finished rises once el_rst has been low for fin_delay cycles.
    // inject 1: frame_start pulse inside EL_RUN; inject 2: write entries
    // 5 and 1 while the second element is being painted.
    task automatic run_frame(input int fin_delay, input int inject, output bit timed_out);
        int bg_cnt;
        int low;
        bit inj_done;
        bg_cnt = 0; low = 0; inj_done = 1'b0;
        painted.delete();
        low_runs.delete();
        done_cnt = 0; ovr_cnt = 0; done_c = -1; last_rise_c = -1; bg_low_c = -1;
        timed_out = 1'b1;
        el_finished = (fin_delay == 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            desc_we     = 1'b0;
            frame_start = 1'b0;
            if (frame_done) begin done_cnt++; done_c = c; end
            if (overrun) ovr_cnt++;
            if (!bg_rst && bg_low_c < 0) bg_low_c = c;
            if (!el_rst) begin
                if (low == 0) painted.push_back(el_desc);
                low++;
            end else if (low != 0) begin
                low_runs.push_back(low);
                last_rise_c = c;
                low = 0;
            end
            if (done_cnt > 0 && !busy) begin
                timed_out = 1'b0;
                break;
            end
            if (!bg_rst) begin
                bg_cnt++;
                bg_finished = (bg_cnt >= 10);
            end else begin
                bg_finished = 1'b0;
            end
            if (fin_delay == 0) el_finished = 1'b1;
            else el_finished = !el_rst && (low >= fin_delay);
            if (inject == 1 && !inj_done && low == 2) begin
                frame_start = 1'b1;
                inj_done    = 1'b1;
            end
            if (inject == 2 && painted.size() == 2 && low == 1) begin
                desc_addr = 5; desc_wdata = b5; desc_we = 1'b1;
            end
            if (inject == 2 && painted.size() == 2 && low == 2) begin
                desc_addr = 1; desc_wdata = b1; desc_we = 1'b1;
            end
            tick();
        end
        el_finished = 1'b0;
        bg_finished = 1'b0;
        desc_we     = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_cmp++; if (bg_rst !== 1'b1) begin n_fail++; $display("FAIL reset_bg_rst got %b want 1", bg_rst); end
        n_cmp++; if (el_rst !== 1'b1) begin n_fail++; $display("FAIL reset_el_rst got %b want 1", el_rst); end
        n_cmp++; if (el_desc !== zero_e) begin n_fail++; $display("FAIL reset_el_desc got %h want 0", el_desc); end
        n_cmp++; if (painting_background !== 1'b1) begin n_fail++; $display("FAIL reset_pbg got %b want 1", painting_background); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_empty_frame();
        bit to;
        clear_table();
        run_frame(4, 0, to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL empty_timeout got %b want 0", to); end
        // c=1 is the third cycle counting the frame_start cycle as 0
        n_cmp++; if (bg_low_c !== 1) begin n_fail++; $display("FAIL empty_bg_fall got %0d want 1", bg_low_c); end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL empty_done_count got %0d want 1", done_cnt); end
        // bg_finished seen at edge 11, then 32 x (FETCH,CHECK) -> DONE at 75
        n_cmp++; if (done_c !== 75) begin n_fail++; $display("FAIL empty_done_cycle got %0d want 75", done_c); end
        n_cmp++; if (painted.size() !== 0) begin n_fail++; $display("FAIL empty_el_rst_pulses got %0d want 0", painted.size()); end
        n_cmp++; if (painting_background !== 1'b1) begin n_fail++; $display("FAIL empty_pbg_after got %b want 1", painting_background); end
    endtask

    task automatic check_three(input string tag, input element_t x0, input element_t x1, input element_t x2);
        element_t exp_q[3];
        exp_q[0] = x0; exp_q[1] = x1; exp_q[2] = x2;
        n_cmp++;
        if (painted.size() !== 3) begin
            n_fail++;
            $display("FAIL %s_count got %0d want 3", tag, painted.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (painted[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL %s_desc%0d got %h want %h", tag, i, painted[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_element_seq();
        bit to;
        wr(0, e0);
        wr(3, e3);
        wr(31, e31);
        run_frame(4, 0, to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL seq_timeout got %b want 0", to); end
        check_three("seq", e0, e3, e31);
        n_cmp++; if (low_runs.size() !== 3) begin n_fail++; $display("FAIL seq_el_rst_pulses got %0d want 3", low_runs.size()); end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL seq_done_count got %0d want 1", done_cnt); end
        n_cmp++; if (done_c !== last_rise_c) begin n_fail++; $display("FAIL seq_done_after_last got %0d want %0d", done_c, last_rise_c); end
        n_cmp++; if (el_desc !== e31) begin n_fail++; $display("FAIL seq_desc_hold got %h want %h", el_desc, e31); end
    endtask

    task automatic test_finished_tied_high();
        bit to;
        run_frame(0, 0, to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL tied_timeout got %b want 0", to); end
        check_three("tied", e0, e3, e31);
        n_cmp++; if (low_runs.size() !== 3) begin n_fail++; $display("FAIL tied_pulses got %0d want 3", low_runs.size()); end
        foreach (low_runs[i]) begin
            n_cmp++;
            if (low_runs[i] !== 2) begin n_fail++; $display("FAIL tied_low_len%0d got %0d want 2", i, low_runs[i]); end
        end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL tied_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_overrun();
        bit to;
        run_frame(4, 1, to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL ovr_timeout got %b want 0", to); end
        n_cmp++; if (ovr_cnt !== 1) begin n_fail++; $display("FAIL ovr_pulse_cycles got %0d want 1", ovr_cnt); end
        check_three("ovr", e0, e3, e31);
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL ovr_done_count got %0d want 1", done_cnt); end
        run_frame(4, 0, to);
        n_cmp++; if (to !== 1'b0 || done_cnt !== 1) begin n_fail++; $display("FAIL ovr_next_frame got done=%0d to=%b want done=1 to=0", done_cnt, to); end
        n_cmp++; if (ovr_cnt !== 0) begin n_fail++; $display("FAIL ovr_next_no_overrun got %0d want 0", ovr_cnt); end
    endtask

    task automatic test_table_update();
        bit to;
        wr(0, zero_e);
        wr(3, zero_e);
        wr(31, zero_e);
        wr(1, a1);
        wr(2, a2);
        wr(5, a5);
        run_frame(5, 2, to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL upd_timeout got %b want 0", to); end
        check_three("upd_f1", a1, a2, b5);
        run_frame(5, 0, to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL upd2_timeout got %b want 0", to); end
        check_three("upd_f2", b1, a2, b5);
    endtask

    task automatic test_async_reset();
        int low;
        int fd;
        bit hit;
        bit to;
        low = 0; fd = 0; hit = 1'b0;
        el_finished = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int c = 0; c < 500 && !hit; c++) begin
            if (frame_done) fd++;
            if (!el_rst) low++;
            if (low == 2) hit = 1'b1;
            else begin
                bg_finished = !bg_rst;
                tick();
            end
        end
        bg_finished = 1'b0;
        n_cmp++; if (hit !== 1'b1) begin n_fail++; $display("FAIL arst_reach_el_run got %b want 1", hit); end
        #3;
        rst = 1'b1;
        #1;
        n_cmp++; if (bg_rst !== 1'b1) begin n_fail++; $display("FAIL arst_bg_rst got %b want 1", bg_rst); end
        n_cmp++; if (el_rst !== 1'b1) begin n_fail++; $display("FAIL arst_el_rst got %b want 1", el_rst); end
        n_cmp++; if (el_desc !== zero_e) begin n_fail++; $display("FAIL arst_el_desc got %h want 0", el_desc); end
        n_cmp++; if (painting_background !== 1'b1) begin n_fail++; $display("FAIL arst_pbg got %b want 1", painting_background); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b want 0", busy); end
        tick();
        if (frame_done) fd++;
        tick();
        if (frame_done) fd++;
        #3;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (frame_done) fd++;
        end
        n_cmp++; if (fd !== 0) begin n_fail++; $display("FAIL arst_no_frame_done got %0d want 0", fd); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_idle_busy got %b want 0", busy); end
        run_frame(4, 0, to);
        n_cmp++; if (to !== 1'b0 || done_cnt !== 1) begin n_fail++; $display("FAIL arst_recover got done=%0d to=%b want done=1 to=0", done_cnt, to); end
    endtask

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        desc_we     = 1'b0;
        desc_addr   = '0;
        desc_wdata  = '0;
        bg_finished = 1'b0;
        el_finished = 1'b0;
        zero_e = '0;
        e0  = mk(1084, 104, 0, 226, 1280, 24);
        e3  = mk(1854, 2, 5, 156, 88, 94);
        e31 = mk(1194, 2, 800, 30, 40, 80);
        a1  = mk(10, 20, 30, 40, 5, 6);
        a2  = mk(100, 200, 300, 400, 7, 8);
        a5  = mk(11, 22, 33, 44, 9, 10);
        b1  = mk(1, 2, 3, 4, 64, 32);
        b5  = mk(2000, 1000, 500, 250, 16, 16);

        test_reset();
        test_empty_frame();
        test_element_seq();
        test_finished_tied_high();
        test_overrun();
        test_table_update();
        test_async_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
